// File: rtl/dsl_sdram_pkg.sv
// Shared definitions for the SDRAM capture/read-back slice: state codes,
// word-to-byte address shift and default data width.
package dsl_sdram_pkg;

   localparam int DSL_DATA_W = 16;
   localparam int ADDR_SHIFT = 2;
   localparam int INFL_W     = 4;
   localparam int CNT_W      = 33;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_READ  = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // Word count for a capture whose last index is 'last'; 33 bits so an
   // all-ones last index still yields a non-zero count.
   function automatic logic [CNT_W-1:0] word_count(input logic [31:0] last);
      return {1'b0, last} + CNT_W'(1);
   endfunction

endpackage

// File: rtl/dread_if.sv
// Read-back bus: sdramc read port plus the downstream host-side FIFO push port.
interface dread_if #(
   parameter int DATA_W = dsl_sdram_pkg::DSL_DATA_W
);

   logic              rd_req;
   logic              rd_valid;
   logic [31:0]       rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_data_valid;
   logic              ds_afull;
   logic              ds_push;
   logic [DATA_W-1:0] ds_data;

   modport master (
      output rd_req, rd_addr, ds_push, ds_data,
      input  rd_valid, rd_data, rd_data_valid, ds_afull
   );

   modport slave (
      input  rd_req, rd_addr, ds_push, ds_data,
      output rd_valid, rd_data, rd_data_valid, ds_afull
   );

endinterface

// File: rtl/dread_addr_gen.sv
// Word index generator for read-back: walks start..last, wraps to 0, and
// counts the words still to be issued.
module dread_addr_gen
   import dsl_sdram_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        advance,
   input  logic [31:0] start_idx,
   input  logic [31:0] last,
   output logic [31:0] addr,
   output logic        more_left
);

   logic [31:0]      idx_q, idx_d;
   logic [31:0]      last_q, last_d;
   logic [CNT_W-1:0] issue_left_q, issue_left_d;

   // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      idx_d        = idx_q;
      last_d       = last_q;
      issue_left_d = issue_left_q;
      if (load) begin
         idx_d        = start_idx;
         last_d       = last;
         issue_left_d = word_count(last);
      end else if (advance && (issue_left_q != '0)) begin
         idx_d        = (idx_q == last_q) ? '0 : idx_q + 32'd1;
         issue_left_d = issue_left_q - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q        <= '0;
         last_q       <= '0;
         issue_left_q <= '0;
      end else begin
         idx_q        <= idx_d;
         last_q       <= last_d;
         issue_left_q <= issue_left_d;
      end
   end

   assign addr      = idx_q << ADDR_SHIFT;
   assign more_left = (issue_left_d != '0);

endmodule

// File: rtl/dread.sv
// SDRAM read-back engine: issues sequential word reads with a bounded number
// outstanding and forwards returned words to the downstream FIFO.
module dread
   import dsl_sdram_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 8,
   parameter int DATA_W          = DSL_DATA_W
) (
   input  logic        sdram_clk,
   input  logic        sdram_rst_n,
   input  logic        read_start,
   input  logic        read_abort,
   input  logic [31:0] sample_last_cnt,
   input  logic [31:0] rd_start_idx,
   dread_if.master     bus,
   output logic        rd_busy,
   output logic        rd_done,
   output logic        rd_err
);

   localparam logic [INFL_W-1:0] MAX_OUT = INFL_W'(MAX_OUTSTANDING);

   state_t             state_q, state_d;
   logic               rd_req_q, rd_req_d;
   logic [INFL_W-1:0]  inflight_q, inflight_d;
   logic [CNT_W-1:0]   returned_left_q, returned_left_d;
   logic               ds_push_q, ds_push_d;
   logic [DATA_W-1:0]  ds_data_q, ds_data_d;
   logic               rd_err_q, rd_err_d;

   logic               start_ok, start_bad, accept, ret_ok, ret_bad, more_left;
   logic [31:0]        rd_addr;

   assign start_ok  = (state_q == ST_IDLE) && read_start && (rd_start_idx <= sample_last_cnt);
   assign start_bad = (state_q == ST_IDLE) && read_start && (rd_start_idx >  sample_last_cnt);
   assign accept    = rd_req_q && bus.rd_valid;
   // A return with nothing in flight is a protocol error and is never counted.
   assign ret_ok    = bus.rd_data_valid && (inflight_q != '0);
   assign ret_bad   = bus.rd_data_valid && (inflight_q == '0);

   dread_addr_gen u_addr_gen (
      .clk       (sdram_clk),
      .rst_n     (sdram_rst_n),
      .load      (start_ok),
      .advance   (accept),
      .start_idx (rd_start_idx),
      .last      (sample_last_cnt),
      .addr      (rd_addr),
      .more_left (more_left)
   );

   always_comb begin
      inflight_d      = inflight_q;
      returned_left_d = returned_left_q;
      rd_req_d        = 1'b0;
      ds_push_d       = 1'b0;
      ds_data_d       = ds_data_q;
      rd_err_d        = rd_err_q;

      if (accept && !ret_ok) inflight_d = inflight_q + INFL_W'(1);
      else if (!accept && ret_ok) inflight_d = inflight_q - INFL_W'(1);

      if (ret_ok)   returned_left_d = returned_left_q - CNT_W'(1);
      if (start_ok) returned_left_d = word_count(sample_last_cnt);

      case (state_q)
         ST_READ: begin
            // A request already on the bus is held until accepted, abort or not.
            rd_req_d = (rd_req_q && !bus.rd_valid) ||
                       (!read_abort && more_left && !bus.ds_afull && (inflight_d < MAX_OUT));
            if (ret_ok) begin
               ds_push_d = 1'b1;
               ds_data_d = bus.rd_data;
            end
         end
         ST_DRAIN: rd_req_d = rd_req_q && !bus.rd_valid;
         default:  rd_req_d = 1'b0;
      endcase

      if (start_ok)             rd_err_d = 1'b0;
      if (start_bad || ret_bad) rd_err_d = 1'b1;
   end

   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) begin
         rd_req_q        <= 1'b0;
         inflight_q      <= '0;
         returned_left_q <= '0;
         ds_push_q       <= 1'b0;
         ds_data_q       <= '0;
         rd_err_q        <= 1'b0;
      end else begin
         rd_req_q        <= rd_req_d;
         inflight_q      <= inflight_d;
         returned_left_q <= returned_left_d;
         ds_push_q       <= ds_push_d;
         ds_data_q       <= ds_data_d;
         rd_err_q        <= rd_err_d;
      end
   end

   always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) state_q <= ST_IDLE;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_ok) state_d = ST_READ;
         ST_READ: begin
            if (returned_left_d == '0) state_d = ST_DONE;
            else if (read_abort)       state_d = ST_DRAIN;
         end
         ST_DRAIN: if ((inflight_d == '0) && !rd_req_d) state_d = ST_IDLE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_busy = (state_q != ST_IDLE);
      rd_done = (state_q == ST_DONE);
   end

   assign bus.rd_req  = rd_req_q;
   assign bus.rd_addr = rd_addr;
   assign bus.ds_push = ds_push_q;
   assign bus.ds_data = ds_data_q;
   assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_dread.sv
// Directed bench for dread: sdramc model with configurable latency/hold-off,
// downstream push monitor, and hand-derived expectations per scenario.
module tb_dread;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        read_start = 1'b0;
   logic        read_abort = 1'b0;
   logic [31:0] sample_last_cnt = '0;
   logic [31:0] rd_start_idx = '0;
   logic        rd_busy, rd_done, rd_err;

   dread_if #(.DATA_W(16)) bus ();

   dread #(.MAX_OUTSTANDING(8), .DATA_W(16)) dut (
      .sdram_clk       (clk),
      .sdram_rst_n     (rst_n),
      .read_start      (read_start),
      .read_abort      (read_abort),
      .sample_last_cnt (sample_last_cnt),
      .rd_start_idx    (rd_start_idx),
      .bus             (bus.master),
      .rd_busy         (rd_busy),
      .rd_done         (rd_done),
      .rd_err          (rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [15:0] data;
   } ret_t;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          lat = 3;
   logic        accept_en = 1'b1;
   logic        hold = 1'b0;
   logic        force_ret = 1'b0;
   ret_t        ret_q[$];
   logic [31:0] acc_addr[$];
   logic [15:0] push_data[$];
   int          ret_cnt = 0;
   int          done_cnt = 0;
   int          stab_err = 0;
   logic        req_pend = 1'b0;
   logic [31:0] pend_addr = '0;

   function automatic logic [15:0] word_of(input logic [31:0] idx);
      return 16'(idx * 32'd37 + 32'd165);
   endfunction

   // sdramc and downstream FIFO model, acting between clock edges.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         ret_q.delete();
         bus.rd_valid      = 1'b0;
         bus.rd_data_valid = 1'b0;
         bus.rd_data       = '0;
         req_pend          = 1'b0;
      end else begin
         bus.rd_valid      = accept_en;
         bus.rd_data_valid = 1'b0;
         if (force_ret) begin
            bus.rd_data_valid = 1'b1;
            bus.rd_data       = 16'hDEAD;
         end else if (!hold && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            bus.rd_data_valid = 1'b1;
            bus.rd_data       = ret_q[0].data;
            void'(ret_q.pop_front());
            ret_cnt++;
         end
         if (bus.rd_req && accept_en) begin
            acc_addr.push_back(bus.rd_addr);
            ret_q.push_back('{cyc + lat, word_of(bus.rd_addr >> 2)});
         end
         if (bus.ds_push) push_data.push_back(bus.ds_data);
         if (rd_done) done_cnt++;
         if (req_pend && (!bus.rd_req || bus.rd_addr != pend_addr)) stab_err++;
         req_pend  = bus.rd_req && !accept_en;
         pend_addr = bus.rd_addr;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input logic [31:0] last, input logic [31:0] sidx);
      sample_last_cnt = last;
      rd_start_idx    = sidx;
      read_start      = 1'b1;
      step();
      read_start      = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (rd_busy && n < budget) begin
         step();
         n++;
      end
      check({tag, "_idle"}, 64'(rd_busy), 64'd0);
   endtask

   // Accepted addresses and pushed data must follow the wrapped index order.
   task automatic check_seq(input string tag, input int acc_b, input int push_b,
                            input int last, input int sidx);
      int errs = 0;
      int n = last + 1;
      check({tag, "_accepts"}, 64'(acc_addr.size() - acc_b), 64'(n));
      check({tag, "_pushes"}, 64'(push_data.size() - push_b), 64'(n));
      for (int k = 0; k < n; k++) begin
         int idx = (sidx + k) % n;
         if (acc_b + k >= acc_addr.size() || acc_addr[acc_b + k] != 32'(idx * 4)) errs++;
         else if (push_b + k >= push_data.size() || push_data[push_b + k] != word_of(32'(idx))) errs++;
      end
      check({tag, "_order"}, 64'(errs), 64'd0);
   endtask

   initial begin
      int ab, pb, db, rb, n;
      bus.ds_afull = 1'b0;

      step(2);
      check("rst_rd_req", 64'(bus.rd_req), 64'd0);
      check("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
      check("rst_ds_push", 64'(bus.ds_push), 64'd0);
      check("rst_busy", 64'(rd_busy), 64'd0);
      check("rst_done", 64'(rd_done), 64'd0);
      check("rst_err", 64'(rd_err), 64'd0);
      rst_n = 1'b1;
      step(2);

      // Basic: 8 words from index 0, returns 3 cycles after accept.
      ab = acc_addr.size(); pb = push_data.size(); db = done_cnt;
      do_start(32'd7, 32'd0);
      check("basic_busy", 64'(rd_busy), 64'd1);
      wait_idle("basic", 200);
      check("basic_first_addr", 64'(acc_addr[ab]), 64'h00);
      check("basic_last_addr", 64'(acc_addr[ab + 7]), 64'h1C);
      check_seq("basic", ab, pb, 7, 0);
      check("basic_done", 64'(done_cnt - db), 64'd1);
      step(2);

      // Wrap: 6..9 then 0..5.
      ab = acc_addr.size(); pb = push_data.size(); db = done_cnt;
      do_start(32'd9, 32'd6);
      wait_idle("wrap", 200);
      check_seq("wrap", ab, pb, 9, 6);
      check("wrap_done", 64'(done_cnt - db), 64'd1);
      step(2);

      // Outstanding limit: returns held for 20 cycles.
      ab = acc_addr.size(); pb = push_data.size(); db = done_cnt;
      hold = 1'b1;
      do_start(32'd15, 32'd0);
      step(20);
      check("limit_accepts", 64'(acc_addr.size() - ab), 64'd8);
      check("limit_req_low", 64'(bus.rd_req), 64'd0);
      hold = 1'b0;
      wait_idle("limit", 300);
      check_seq("limit", ab, pb, 15, 0);
      check("limit_done", 64'(done_cnt - db), 64'd1);
      step(2);

      // Backpressure: a pending request is completed, then issue stops.
      ab = acc_addr.size(); pb = push_data.size(); db = done_cnt;
      accept_en = 1'b0;
      do_start(32'd5, 32'd2);
      n = 0;
      while (!bus.rd_req && n < 10) begin
         step();
         n++;
      end
      check("bp_req_up", 64'(bus.rd_req), 64'd1);
      bus.ds_afull = 1'b1;
      step(3);
      check("bp_req_held", 64'(bus.rd_req), 64'd1);
      check("bp_addr_held", 64'(bus.rd_addr), 64'h08);
      check("bp_no_accept", 64'(acc_addr.size() - ab), 64'd0);
      accept_en = 1'b1;
      step(4);
      check("bp_one_accept", 64'(acc_addr.size() - ab), 64'd1);
      check("bp_req_low", 64'(bus.rd_req), 64'd0);
      bus.ds_afull = 1'b0;
      wait_idle("bp", 200);
      check_seq("bp", ab, pb, 5, 2);
      check("bp_done", 64'(done_cnt - db), 64'd1);
      step(2);

      // Abort with 4 reads in flight: those returns are dropped, no done.
      ab = acc_addr.size(); pb = push_data.size(); db = done_cnt; rb = ret_cnt;
      lat = 4;
      do_start(32'd99, 32'd0);
      n = 0;
      while (acc_addr.size() - ab < 9 && n < 50) begin
         step();
         n++;
      end
      read_abort = 1'b1;
      step();
      read_abort = 1'b0;
      wait_idle("abort", 100);
      check("abort_accepts", 64'(acc_addr.size() - ab), 64'd10);
      check("abort_returns_at_idle", 64'(ret_cnt - rb), 64'd10);
      check("abort_pushes", 64'(push_data.size() - pb), 64'd6);
      n = 0;
      for (int k = 0; k < 6; k++)
         if (pb + k >= push_data.size() || push_data[pb + k] != word_of(32'(k))) n++;
      check("abort_push_order", 64'(n), 64'd0);
      check("abort_no_done", 64'(done_cnt - db), 64'd0);
      check("abort_no_err", 64'(rd_err), 64'd0);
      lat = 3;
      step(3);

      // Errors: unexpected return in IDLE, then bad start index.
      pb = push_data.size(); ab = acc_addr.size();
      force_ret = 1'b1;
      step();
      force_ret = 1'b0;
      step(2);
      check("err_unexp_ret", 64'(rd_err), 64'd1);
      check("err_unexp_no_push", 64'(push_data.size() - pb), 64'd0);
      do_start(32'd1, 32'd0);
      check("err_clear_on_start", 64'(rd_err), 64'd0);
      wait_idle("err_ok1", 100);
      step(2);
      ab = acc_addr.size();
      do_start(32'd3, 32'd5);
      step(2);
      check("err_bad_start", 64'(rd_err), 64'd1);
      check("err_bad_start_idle", 64'(rd_busy), 64'd0);
      check("err_bad_start_no_req", 64'(acc_addr.size() - ab), 64'd0);
      ab = acc_addr.size(); pb = push_data.size();
      do_start(32'd2, 32'd2);
      check("err_clear_again", 64'(rd_err), 64'd0);
      wait_idle("err_ok2", 100);
      check_seq("err_ok2", ab, pb, 2, 2);
      step(2);

      // Reset mid-operation discards everything, no done.
      db = done_cnt;
      do_start(32'd50, 32'd0);
      step(10);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(rd_busy), 64'd0);
      check("midrst_req", 64'(bus.rd_req), 64'd0);
      check("midrst_push", 64'(bus.ds_push), 64'd0);
      step(2);
      rst_n = 1'b1;
      step(5);
      check("midrst_no_done", 64'(done_cnt - db), 64'd0);
      check("midrst_idle", 64'(rd_busy), 64'd0);

      check("req_addr_stable", 64'(stab_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
